// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multi-cycle RV32I datapath.
// Ports:
//   clock, reset (sync, active-high); opcode, mem_ready, branch_taken in.
//   pc_load, old_pc_load, ir_load, mem_read, mem_write, addr_sel,
//   reg_write, alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, trap out.
// Build option: define MULTICYCLE_CONTROL_TRAP_EN to park illegal
// opcodes in a TRAP state; otherwise they retire as a NOP.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_load,
  output logic       old_pc_load,
  output logic       ir_load,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic [1:0] wb_sel,
  output logic       trap
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

  state_e state_q;
  state_e state_d;
  state_e illegal_nxt;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
  assign illegal_nxt = S_TRAP;
`else
  assign illegal_nxt = S_FETCH;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    old_pc_load = 1'b0;
    ir_load     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_op      = 2'd0;
    pc_src      = 1'b0;
    wb_sel      = 2'd0;
    trap        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd2;
        // PC+4 is written back straight from the ALU in the ready cycle.
        if (mem_ready) begin
          ir_load     = 1'b1;
          old_pc_load = 1'b1;
          pc_load     = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/JAL target computed here and held in the ALU out reg.
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        unique case (opcode)
          OP_R:     state_d = S_EXEC_R;
          OP_I:     state_d = S_EXEC_I;
          OP_LOAD:  state_d = S_MEM_ADDR;
          OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_LUI:   state_d = S_LUI;
          OP_AUIPC: state_d = S_AUIPC;
          OP_SYS:   state_d = S_FETCH;
          default:  state_d = illegal_nxt;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_op    = 2'd2;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_op    = 2'd2;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        addr_sel  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_op    = 2'd1;
        pc_load   = branch_taken;
        pc_src    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_load   = 1'b1;
        pc_src    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        // Target bit 0 is cleared in the datapath, not here.
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_load   = 1'b1;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = 2'd3;
        alu_src_b = 2'd1;
        state_d   = S_WB_ALU;
      end
      S_AUIPC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        state_d   = S_WB_ALU;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        trap    = 1'b1;
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every strobe, including the FETCH read.
    if (reset) begin
      pc_load     = 1'b0;
      old_pc_load = 1'b0;
      ir_load     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      alu_op      = 2'd0;
      pc_src      = 1'b0;
      wb_sel      = 2'd0;
      trap        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random + directed bench for multicycle_control.
// Reference model: per-instruction phase plan kept as a string queue.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_load, old_pc_load, ir_load;
  logic       mem_read, mem_write, addr_sel, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic       pc_src, trap;

  multicycle_control dut (
    .clock(clock),
    .reset(reset),
    .opcode(opcode),
    .mem_ready(mem_ready),
    .branch_taken(branch_taken),
    .pc_load(pc_load),
    .old_pc_load(old_pc_load),
    .ir_load(ir_load),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr_sel(addr_sel),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_src(pc_src),
    .wb_sel(wb_sel),
    .trap(trap)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

`ifdef MULTICYCLE_CONTROL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    ir_cyc[$];
  string q[$];

  logic [16:0] got_v;
  assign got_v = {pc_load, old_pc_load, ir_load, mem_read, mem_write,
                  addr_sel, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_src, wb_sel, trap};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [16:0] expect_vec(string ph, logic mr, logic bt);
    logic       pcl, opl, irl, mrd, mwr, as, rw, pcs, tr;
    logic [1:0] a, b, op, wb;
    {pcl, opl, irl, mrd, mwr, as, rw, pcs, tr} = '0;
    {a, b, op, wb} = '0;
    case (ph)
      "FETCH": begin
        mrd = 1; b = 2;
        if (mr) {pcl, opl, irl} = 3'b111;
      end
      "DECODE":   begin a = 1; b = 1; end
      "EXEC_R":   begin a = 2; op = 2; end
      "EXEC_I":   begin a = 2; b = 1; op = 2; end
      "MEM_ADDR": begin a = 2; b = 1; end
      "MEM_RD":   begin mrd = 1; as = 1; end
      "MEM_WR":   begin mwr = 1; as = 1; end
      "WB_ALU":   rw = 1;
      "WB_MEM":   begin rw = 1; wb = 1; end
      "BRANCH":   begin a = 2; op = 1; pcl = bt; pcs = 1; end
      "JAL":      begin rw = 1; wb = 2; pcl = 1; pcs = 1; end
      "JALR":     begin a = 2; b = 1; rw = 1; wb = 2; pcl = 1; end
      "LUI":      begin a = 3; b = 1; end
      "AUIPC":    begin a = 1; b = 1; end
      "TRAP":     tr = 1;
      default: ;
    endcase
    return {pcl, opl, irl, mrd, mwr, as, rw, a, b, op, pcs, wb, tr};
  endfunction

  task automatic plan(input logic [6:0] op);
    case (op)
      OP_R:     begin q.push_back("EXEC_R"); q.push_back("WB_ALU"); end
      OP_I:     begin q.push_back("EXEC_I"); q.push_back("WB_ALU"); end
      OP_LOAD:  begin
        q.push_back("MEM_ADDR"); q.push_back("MEM_RD");
        q.push_back("WB_MEM");
      end
      OP_STORE: begin q.push_back("MEM_ADDR"); q.push_back("MEM_WR"); end
      OP_BR:    q.push_back("BRANCH");
      OP_JAL:   q.push_back("JAL");
      OP_JALR:  q.push_back("JALR");
      OP_LUI:   begin q.push_back("LUI"); q.push_back("WB_ALU"); end
      OP_AUIPC: begin q.push_back("AUIPC"); q.push_back("WB_ALU"); end
      OP_SYS:   ;
      default:  if (TRAP_EN) q.push_back("TRAP");
    endcase
  endtask

  task automatic advance(input logic r, input logic [6:0] op,
                         input logic mr);
    string ph;
    if (r) begin
      q.delete();
      q.push_back("FETCH");
      return;
    end
    ph = q[0];
    if (ph == "TRAP") return;
    if ((ph == "FETCH" || ph == "MEM_RD" || ph == "MEM_WR") && !mr) return;
    void'(q.pop_front());
    if (ph == "FETCH") q.push_back("DECODE");
    if (ph == "DECODE") plan(op);
    if (q.size() == 0) q.push_back("FETCH");
  endtask

  task automatic step(input logic r, input logic [6:0] op,
                      input logic mr, input logic bt);
    logic [16:0] e;
    reset = r; opcode = op; mem_ready = mr; branch_taken = bt;
    @(negedge clock);
    e = r ? 17'd0 : expect_vec(q[0], mr, bt);
    check({"ctl@", q[0]}, 32'(got_v), 32'(e));
    if (ir_load) ir_cyc.push_back(cyc);
    advance(r, op, mr);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  logic [6:0] op_tab [11];
  logic       ld_mr  [11];
  int         base;
  logic [6:0] rop;

  initial begin
    op_tab = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR,
               OP_LUI, OP_AUIPC, OP_SYS, 7'b0000000};
    ld_mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1};
    reset = 1; opcode = 0; mem_ready = 1; branch_taken = 0;
    q.push_back("FETCH");
    @(posedge clock);
    #1;

    // ALU-immediate: 4 cycles, single pc_load and reg_write
    step(1, OP_I, 1, 0);
    step(1, OP_I, 1, 0);
    ir_cyc.delete();
    repeat (5) step(0, OP_I, 1, 0);
    check("alu_ir_n", ir_cyc.size(), 2);
    if (ir_cyc.size() >= 2) check("alu_lat", ir_cyc[1] - ir_cyc[0], 4);

    // Load with 2 fetch waits and 3 read waits: 10 cycles
    step(1, OP_LOAD, 1, 0);
    ir_cyc.delete();
    base = cyc;
    for (int i = 0; i < 11; i++) step(0, OP_LOAD, ld_mr[i], 0);
    check("ld_ir_n", ir_cyc.size(), 2);
    if (ir_cyc.size() >= 2) begin
      check("ld_first", ir_cyc[0] - base, 2);
      check("ld_lat", ir_cyc[1] - base, 10);
    end

    // Branch taken then not taken: 3 cycles each
    step(1, OP_BR, 1, 0);
    ir_cyc.delete();
    for (int i = 0; i < 7; i++) step(0, OP_BR, 1, i < 3);
    check("br_ir_n", ir_cyc.size(), 3);
    if (ir_cyc.size() >= 3) begin
      check("br_lat0", ir_cyc[1] - ir_cyc[0], 3);
      check("br_lat1", ir_cyc[2] - ir_cyc[1], 3);
    end

    // JAL and JALR
    step(1, OP_JAL, 1, 0);
    repeat (3) step(0, OP_JAL, 1, 0);
    repeat (3) step(0, OP_JALR, 1, 0);

    // Illegal opcode held for 22 cycles
    step(1, 7'b0000000, 1, 0);
    repeat (22) step(0, 7'b0000000, 1, 0);
    check("trap_hold", trap, TRAP_EN);

    // Store stalled in MEM_WR, then reset
    step(1, OP_STORE, 1, 0);
    step(0, OP_STORE, 1, 0);
    step(0, OP_STORE, 1, 0);
    step(0, OP_STORE, 1, 0);
    step(0, OP_STORE, 0, 0);
    step(1, OP_STORE, 1, 0);
    step(0, OP_STORE, 0, 0);
    step(0, OP_STORE, 1, 0);

    // Random traffic
    rop = OP_I;
    for (int i = 0; i < 3000; i++) begin
      if (q[0] == "FETCH") begin
        int k;
        k = $urandom_range(11);
        rop = (k == 11) ? 7'($urandom) : op_tab[k];
      end
      step($urandom_range(49) == 0, rop,
           $urandom_range(9) < 7, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
